// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// The request is held with a stable address until the memory answers with one ack cycle.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [19:0]           mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads 20-bit words over a req/ack bus and presents
// them to the control unit, raising trap / address-violation / ack-timeout flags.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_enable,
  input  logic                     instr_taken,
  input  logic                     branch_valid,
  input  logic [ADDR_WIDTH-1:0]    branch_target,
  input  logic                     trap_clear,
  instruction_fetch_unit_if.master mem,
  output logic [19:0]              instruction,
  output logic                     instr_valid,
  output logic [ADDR_WIDTH-1:0]    pc,
  output logic                     trap_mode_flag,
  output logic                     mem_violation_flag,
  output logic                     mem_corruption_flag
);

  localparam int                    CNT_W       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP,
    S_VIOL,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [19:0]           instr_q, instr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  valid_q, valid_d;
  logic                  trap_q, trap_d;
  logic                  viol_q, viol_d;
  logic                  corr_q, corr_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (branch_valid) begin
          pc_d = branch_target;
        end else if (fetch_enable) begin
          state_d = ({1'b0, pc_q} >= DEPTH_LIMIT) ? S_VIOL : S_REQ;
        end
      end

      S_REQ: begin
        count_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          state_d = S_HOLD;
        end else begin
          count_d = count_q + 1'b1;
          if (count_d == TIMEOUT_CNT) begin
            state_d = S_FAULT;
          end
        end
      end

      S_HOLD: begin
        // A branch arriving with the consume beats the sequential increment.
        if (instr_taken) begin
          pc_d    = branch_valid ? branch_target : pc_q + 1'b1;
          state_d = (instr_q == 20'b0) ? S_TRAP : S_IDLE;
        end else if (branch_valid) begin
          pc_d = branch_target;
        end
      end

      S_TRAP: begin
        if (trap_clear) begin
          state_d = S_IDLE;
        end
      end

      S_VIOL: begin
        if (trap_clear) begin
          pc_d    = RESET_PC;
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        // The PC is kept so that clearing the fault refetches the same word.
        if (trap_clear) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    mem_req_d  = (state_d == S_REQ) || (state_d == S_WAIT);
    mem_addr_d = mem_req_d ? pc_d : '0;
    valid_d    = (state_d == S_HOLD);
    trap_d     = (state_d == S_TRAP);
    viol_d     = (state_d == S_VIOL);
    corr_d     = (state_d == S_FAULT);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      trap_q     <= 1'b0;
      viol_q     <= 1'b0;
      corr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      trap_q     <= trap_d;
      viol_q     <= viol_d;
      corr_q     <= corr_d;
    end
  end

  assign mem.mem_req          = mem_req_q;
  assign mem.mem_addr         = mem_addr_q;
  assign instruction          = instr_q;
  assign instr_valid          = valid_q;
  assign pc                   = pc_q;
  assign trap_mode_flag       = trap_q;
  assign mem_violation_flag   = viol_q;
  assign mem_corruption_flag  = corr_q;

endmodule
